// File: rtl/memlog_pkg.sv
// memlog_pkg: shared definitions for the MEMLog capture sequencer.
//   - cmd_e         : host command codes (NOP/START/DUMP/ABORT)
//   - state_e       : 3-bit sequencer state encoding
//   - MEMLOG_DATA_W : MEMLog word width
//   - is_busy()     : true for every state except idle and done
package memlog_pkg;

  localparam int unsigned MEMLOG_DATA_W = 32;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_START = 2'b01,
    CMD_DUMP  = 2'b10,
    CMD_ABORT = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StArm     = 3'd1,
    StCapture = 3'd2,
    StDone    = 3'd3,
    StRdStart = 3'd4,
    StRdWait  = 3'd5,
    StRdOut   = 3'd6
  } state_e;

  function automatic logic is_busy(input state_e s);
    return (s != StIdle) && (s != StDone);
  endfunction

endpackage

// File: rtl/memlog_watchdog.sv
// memlog_watchdog: capture watchdog counter.
// Ports:
//   clk      in  clock, rising edge
//   i_rst    in  asynchronous active-high reset
//   i_clear  in  zero the count (takes priority over enable)
//   i_enable in  count one cycle
//   o_expire out high on the enabled cycle that completes 2**TIMEOUT_W-1 counted cycles
module memlog_watchdog #(
  parameter int unsigned TIMEOUT_W = 20
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [TIMEOUT_W-1:0] CNT_ONE = TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] r_count;
  logic [TIMEOUT_W-1:0] w_count_inc;

  assign w_count_inc = r_count + CNT_ONE;
  // Fire when this cycle's increment reaches all-ones, so expiry lands exactly on the
  // (2**TIMEOUT_W-1)th enabled cycle.
  assign o_expire    = i_enable && (&w_count_inc);

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_count_inc;
    end
  end

endmodule

// File: rtl/memlog_ctrl.sv
// memlog_ctrl: sequencer for the MEMLog capture BRAM. Turns host commands into
// MEMLog run/read pulses, then walks the read address and streams every log word
// out over a valid/ready interface.
// Ports:
//   clk, i_rst                       clock / async active-high reset
//   i_cmd_valid, i_cmd               host command strobe and code
//   o_cmd_err                        1-cycle pulse: START/DUMP rejected while busy
//   i_mem_full                       MEMLog full flag
//   o_run_log, o_read_log            1-cycle MEMLog control pulses
//   o_addr_log_to_mem                MEMLog read address
//   i_data_log_from_mem              MEMLog read data
//   o_data, o_data_valid, i_data_ready  word stream toward the host bridge
//   o_busy, o_done, o_timeout        status (timeout is sticky until next START)
module memlog_ctrl
  import memlog_pkg::*;
#(
  parameter int unsigned BRAM_ADDR_WIDTH = 15,
  parameter int unsigned RD_LATENCY      = 2,
  parameter int unsigned TIMEOUT_W       = 20
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic                       i_cmd_valid,
  input  logic [1:0]                 i_cmd,
  output logic                       o_cmd_err,
  input  logic                       i_mem_full,
  output logic                       o_run_log,
  output logic                       o_read_log,
  output logic [BRAM_ADDR_WIDTH-1:0] o_addr_log_to_mem,
  input  logic [MEMLOG_DATA_W-1:0]   i_data_log_from_mem,
  output logic [MEMLOG_DATA_W-1:0]   o_data,
  output logic                       o_data_valid,
  input  logic                       i_data_ready,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_timeout
);

  localparam int unsigned LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [LAT_W-1:0]           LAT_LAST = LAT_W'(RD_LATENCY - 1);
  localparam logic [LAT_W-1:0]           LAT_ONE  = LAT_W'(1);
  localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_ONE = BRAM_ADDR_WIDTH'(1);

  state_e                     r_state;
  logic [BRAM_ADDR_WIDTH-1:0] r_addr;
  logic [LAT_W-1:0]           r_lat;
  logic [MEMLOG_DATA_W-1:0]   r_data;
  logic                       r_data_valid;
  logic                       r_run_log;
  logic                       r_read_log;
  logic                       r_cmd_err;
  logic                       r_timeout;

  cmd_e w_cmd;
  logic w_busy;
  logic w_abort;
  logic w_start_or_dump;
  logic w_wd_expire;

  assign w_cmd           = cmd_e'(i_cmd);
  assign w_busy          = is_busy(r_state);
  assign w_abort         = i_cmd_valid && (w_cmd == CMD_ABORT);
  assign w_start_or_dump = i_cmd_valid && ((w_cmd == CMD_START) || (w_cmd == CMD_DUMP));

  memlog_watchdog #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_watchdog (
    .clk      (clk),
    .i_rst    (i_rst),
    .i_clear  (r_state == StArm),
    .i_enable (r_state == StCapture),
    .o_expire (w_wd_expire)
  );

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_addr       <= '0;
      r_lat        <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_run_log    <= 1'b0;
      r_read_log   <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_run_log  <= 1'b0;
      r_read_log <= 1'b0;
      r_cmd_err  <= 1'b0;
      if (w_busy && w_abort) begin
        // Abort wins over everything, including a same-cycle stream transfer.
        r_state      <= StIdle;
        r_data_valid <= 1'b0;
        r_addr       <= '0;
        r_lat        <= '0;
      end else begin
        if (w_busy && w_start_or_dump) r_cmd_err <= 1'b1;
        unique case (r_state)
          StIdle, StDone: begin
            if (i_cmd_valid) begin
              case (w_cmd)
                CMD_START: begin
                  r_state   <= StArm;
                  r_run_log <= 1'b1;
                  r_timeout <= 1'b0;
                end
                CMD_DUMP: begin
                  r_state    <= StRdStart;
                  r_read_log <= 1'b1;
                  r_addr     <= '0;
                  r_lat      <= '0;
                end
                CMD_ABORT: r_state <= StIdle;
                default:   ;
              endcase
            end
          end
          StArm: r_state <= StCapture;
          StCapture: begin
            if (i_mem_full) begin
              r_state <= StDone;
            end else if (w_wd_expire) begin
              r_state   <= StIdle;
              r_timeout <= 1'b1;
            end
          end
          StRdStart: r_state <= StRdWait;
          StRdWait: begin
            if (r_lat == LAT_LAST) begin
              r_data       <= i_data_log_from_mem;
              r_data_valid <= 1'b1;
              r_state      <= StRdOut;
            end else begin
              r_lat <= r_lat + LAT_ONE;
            end
          end
          StRdOut: begin
            if (i_data_ready) begin
              r_data_valid <= 1'b0;
              r_lat        <= '0;
              if (&r_addr) begin
                r_state <= StIdle;
                r_addr  <= '0;
              end else begin
                r_addr  <= r_addr + ADDR_ONE;
                r_state <= StRdWait;
              end
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign o_busy            = w_busy;
  assign o_done            = (r_state == StDone);
  assign o_cmd_err         = r_cmd_err;
  assign o_run_log         = r_run_log;
  assign o_read_log        = r_read_log;
  assign o_addr_log_to_mem = r_addr;
  assign o_data            = r_data;
  assign o_data_valid      = r_data_valid;
  assign o_timeout         = r_timeout;

endmodule
